// File: rtl/eq_sched_pkg.sv
// eq_sched_pkg
//   Shared definitions for the equation-datapath scheduler: FSM state
//   encoding, requester IDs (which double as the dp_sel operand encoding),
//   the default watchdog limit and the watchdog counter width.
package eq_sched_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ISSUE  = 2'd1,
        ST_WAIT   = 2'd2,
        ST_RETIRE = 2'd3
    } state_t;

    // Requester identity; the numeric value is driven directly onto dp_sel.
    typedef enum logic [1:0] {
        ID_ALT  = 2'd0,
        ID_BAT  = 2'd1,
        ID_BIST = 2'd2
    } req_id_t;

    localparam int DEFAULT_TIMEOUT = 15;
    localparam int WDOG_W          = 8;

endpackage

// File: rtl/eq_watchdog.sv
// eq_watchdog
//   Counts datapath WAIT cycles that pass without completion and flags the
//   cycle on which the LIMIT-th such cycle occurs.
//   Ports:
//     clk, rst_n  clock, asynchronous active-low reset
//     clear       zero the counter (asserted while the operation is issued)
//     count_en    this cycle is a WAIT cycle without dp_done
//     expired     combinational: the current WAIT cycle is the LIMIT-th one
module eq_watchdog
    import eq_sched_pkg::*;
#(
    parameter int LIMIT = DEFAULT_TIMEOUT
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic count_en,
    output logic expired
);

    // The counter holds the number of WAIT cycles already elapsed, so the
    // LIMIT-th cycle is the one where it still reads LIMIT-1.
    localparam logic [WDOG_W-1:0] LAST = WDOG_W'(LIMIT - 1);

    logic [WDOG_W-1:0] count;

    // NOTE: sequential state is always written with non-blocking assignments
    // so every flop samples pre-edge values regardless of block ordering.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (count_en && !expired) begin
            count <= count + 1'b1;
        end
    end

    assign expired = count_en && (count == LAST);

endmodule

// File: rtl/eq_scheduler.sv
// eq_scheduler
//   Arbitrates the shared equation datapath between altitude, battery and
//   BIST requesters and sequences each operation with a start/done handshake
//   guarded by a watchdog.
//   Ports:
//     clk, rst_n                     clock, asynchronous active-low reset
//     enable                         permits altitude/battery grants
//     req_alt, req_bat, req_bist     level requests (BIST has priority and
//                                    ignores enable)
//     dp_start                       one-cycle start pulse to the datapath
//     dp_sel                         operand select, held ISSUE..RETIRE
//     dp_done                        datapath completion pulse
//     done_alt, done_bat, done_bist  one-cycle completion pulse to the owner
//     err_pulse                      one-cycle watchdog abort pulse
//     timeout_err                    sticky abort flag
//     busy                           operation in flight
//     op_count                       completed operations, wraps at 256
module eq_scheduler
    import eq_sched_pkg::*;
#(
    parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       enable,
    input  logic       req_alt,
    input  logic       req_bat,
    input  logic       req_bist,
    output logic       dp_start,
    output logic [1:0] dp_sel,
    input  logic       dp_done,
    output logic       done_alt,
    output logic       done_bat,
    output logic       done_bist,
    output logic       err_pulse,
    output logic       timeout_err,
    output logic       busy,
    output logic [7:0] op_count
);

    state_t  state;
    req_id_t owner;
    req_id_t last_served;

    logic    grant_valid;
    req_id_t grant_id;
    logic    wd_expired;

    // The registered owner is the operand select; it only changes on a grant,
    // so dp_sel is stable from ISSUE through RETIRE.
    assign dp_sel = owner;

    // Arbitration: BIST first, then altitude/battery when enabled, with ties
    // going to whichever of the two was not served last.
    // NOTE: every variable written here gets a default first so no path
    // leaves it unassigned, which would otherwise infer a latch.
    always_comb begin
        grant_valid = 1'b0;
        grant_id    = ID_ALT;
        if (req_bist) begin
            grant_valid = 1'b1;
            grant_id    = ID_BIST;
        end else if (enable && req_alt && req_bat) begin
            grant_valid = 1'b1;
            grant_id    = (last_served == ID_ALT) ? ID_BAT : ID_ALT;
        end else if (enable && req_alt) begin
            grant_valid = 1'b1;
            grant_id    = ID_ALT;
        end else if (enable && req_bat) begin
            grant_valid = 1'b1;
            grant_id    = ID_BAT;
        end
    end

    eq_watchdog #(
        .LIMIT (TIMEOUT)
    ) u_watchdog (
        .clk      (clk),
        .rst_n    (rst_n),
        .clear    (state == ST_ISSUE),
        .count_en ((state == ST_WAIT) && !dp_done),
        .expired  (wd_expired)
    );

    // All outputs are registered: pulses are set on the edge entering the
    // state in which they are visible and defaulted low every other cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_IDLE;
            owner       <= ID_ALT;
            last_served <= ID_BAT;
            dp_start    <= 1'b0;
            done_alt    <= 1'b0;
            done_bat    <= 1'b0;
            done_bist   <= 1'b0;
            err_pulse   <= 1'b0;
            timeout_err <= 1'b0;
            busy        <= 1'b0;
            op_count    <= 8'd0;
        end else begin
            dp_start  <= 1'b0;
            done_alt  <= 1'b0;
            done_bat  <= 1'b0;
            done_bist <= 1'b0;
            err_pulse <= 1'b0;

            case (state)
                ST_IDLE: begin
                    if (grant_valid) begin
                        state    <= ST_ISSUE;
                        owner    <= grant_id;
                        dp_start <= 1'b1;
                        busy     <= 1'b1;
                    end
                end

                ST_ISSUE: begin
                    state <= ST_WAIT;
                end

                ST_WAIT: begin
                    // Completion is tested first so a dp_done on the final
                    // watchdog cycle still counts as success.
                    if (dp_done) begin
                        state    <= ST_RETIRE;
                        op_count <= op_count + 8'd1;
                        case (owner)
                            ID_ALT:  done_alt  <= 1'b1;
                            ID_BAT:  done_bat  <= 1'b1;
                            default: done_bist <= 1'b1;
                        endcase
                        if (owner != ID_BIST) begin
                            last_served <= owner;
                        end
                    end else if (wd_expired) begin
                        state       <= ST_RETIRE;
                        err_pulse   <= 1'b1;
                        timeout_err <= 1'b1;
                        if (owner != ID_BIST) begin
                            last_served <= owner;
                        end
                    end
                end

                ST_RETIRE: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                end

                default: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_eq_scheduler.sv
// tb_eq_scheduler
//   Directed scoreboard bench for eq_scheduler. The stimulus thread pushes
//   the expected completion/abort records; a monitor pops and compares them
//   whenever a done_* or err_pulse appears. An environment process models
//   the requesters (drop on their own done/err) and a datapath that answers
//   a configurable number of cycles after dp_start (0 = never).
module tb_eq_scheduler;

    localparam int K_ALT  = 0;
    localparam int K_BAT  = 1;
    localparam int K_BIST = 2;
    localparam int K_ERR  = 3;

    typedef struct {
        int kind;
        int sel;
        int cnt;
        int lat;   // cycles from dp_start to the pulse
        int gap;   // cycles since the previous pulse, 0 = not checked
    } exp_t;

    logic       clk;
    logic       rst_n;
    logic       enable;
    logic       req_alt;
    logic       req_bat;
    logic       req_bist;
    logic       dp_start;
    logic [1:0] dp_sel;
    logic       dp_done;
    logic       done_alt;
    logic       done_bat;
    logic       done_bist;
    logic       err_pulse;
    logic       timeout_err;
    logic       busy;
    logic [7:0] op_count;

    int   errors;
    int   checks;
    int   cyc;
    exp_t exp_q[$];

    // Written only by the stimulus thread.
    int tgt_alt, tgt_bat, tgt_bist;
    int delay;
    // Written only by the environment process.
    int served_alt, served_bat, served_bist;
    int pending;
    // Written only by the monitor.
    int starts;
    int start_cyc;
    int last_evt_cyc;

    eq_scheduler #(
        .TIMEOUT (15)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .enable      (enable),
        .req_alt     (req_alt),
        .req_bat     (req_bat),
        .req_bist    (req_bist),
        .dp_start    (dp_start),
        .dp_sel      (dp_sel),
        .dp_done     (dp_done),
        .done_alt    (done_alt),
        .done_bat    (done_bat),
        .done_bist   (done_bist),
        .err_pulse   (err_pulse),
        .timeout_err (timeout_err),
        .busy        (busy),
        .op_count    (op_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic expect_op(input int kind, input int sel, input int cnt, input int lat, input int gap);
        exp_t e;
        e.kind = kind;
        e.sel  = sel;
        e.cnt  = cnt;
        e.lat  = lat;
        e.gap  = gap;
        exp_q.push_back(e);
    endtask

    task automatic wait_drain(input int max_cycles);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < max_cycles; i++) begin
            @(negedge clk);
            if (exp_q.size() == 0 && !busy) begin
                ok = 1'b1;
                break;
            end
        end
        check("drain_within_budget", 32'(ok), 32'd1);
    endtask

    task automatic do_reset();
        tgt_alt  = served_alt;
        tgt_bat  = served_bat;
        tgt_bist = served_bist;
        rst_n    = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    // Requesters and datapath: update one time unit after each rising edge.
    initial begin
        dp_done  = 1'b0;
        req_alt  = 1'b0;
        req_bat  = 1'b0;
        req_bist = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (!rst_n) begin
                pending = 0;
                dp_done = 1'b0;
            end else begin
                dp_done = 1'b0;
                if (dp_start) begin
                    pending = delay;
                end else if (pending > 0) begin
                    pending--;
                    if (pending == 0) dp_done = 1'b1;
                end
                if (done_alt  || (err_pulse && dp_sel == 2'd0)) served_alt++;
                if (done_bat  || (err_pulse && dp_sel == 2'd1)) served_bat++;
                if (done_bist || (err_pulse && dp_sel == 2'd2)) served_bist++;
            end
            req_alt  = (tgt_alt  > served_alt);
            req_bat  = (tgt_bat  > served_bat);
            req_bist = (tgt_bist > served_bist);
        end
    end

    // Monitor / scoreboard.
    initial begin
        exp_t e;
        int   kind;
        forever begin
            @(negedge clk);
            if (dp_start) begin
                starts++;
                start_cyc = cyc;
            end
            if (done_alt || done_bat || done_bist || err_pulse) begin
                kind = err_pulse ? K_ERR : done_bist ? K_BIST : done_bat ? K_BAT : K_ALT;
                check("single_pulse",
                      32'(done_alt) + 32'(done_bat) + 32'(done_bist) + 32'(err_pulse), 32'd1);
                if (exp_q.size() == 0) begin
                    check("unexpected_event_kind", 32'(kind), 32'd4);
                end else begin
                    e = exp_q.pop_front();
                    check("event_kind", 32'(kind), 32'(e.kind));
                    check("event_dp_sel", 32'(dp_sel), 32'(e.sel));
                    check("event_op_count", 32'(op_count), 32'(e.cnt));
                    check("event_latency", 32'(cyc - start_cyc), 32'(e.lat));
                    if (e.gap != 0) check("event_spacing", 32'(cyc - last_evt_cyc), 32'(e.gap));
                end
                last_evt_cyc = cyc;
            end
        end
    end

    initial begin
        int s0;
        bit seen;
        rst_n  = 1'b0;
        enable = 1'b0;
        delay  = 1;
        repeat (3) @(negedge clk);

        // Reset values.
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_dp_start", 32'(dp_start), 32'd0);
        check("rst_dp_sel", 32'(dp_sel), 32'd0);
        check("rst_done", 32'({done_alt, done_bat, done_bist}), 32'd0);
        check("rst_err", 32'({err_pulse, timeout_err}), 32'd0);
        check("rst_op_count", 32'(op_count), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Tie between altitude and battery: alt, bat, alt, bat every 4 cycles.
        enable = 1'b1;
        delay  = 1;
        expect_op(K_ALT, 0, 1, 2, 0);
        expect_op(K_BAT, 1, 2, 2, 4);
        expect_op(K_ALT, 0, 3, 2, 4);
        expect_op(K_BAT, 1, 4, 2, 4);
        tgt_alt += 2;
        tgt_bat += 2;
        wait_drain(100);
        check("rr_op_count", 32'(op_count), 32'd4);

        // Single altitude op, datapath answers 3 cycles after start.
        do_reset();
        enable = 1'b1;
        delay  = 3;
        s0     = starts;
        expect_op(K_ALT, 0, 1, 4, 0);
        tgt_alt += 1;
        wait_drain(100);
        check("alt_single_start", 32'(starts - s0), 32'd1);
        check("alt_op_count", 32'(op_count), 32'd1);

        // BIST served while disabled; altitude waits for enable.
        do_reset();
        enable = 1'b0;
        delay  = 2;
        expect_op(K_BIST, 2, 1, 3, 0);
        tgt_bist += 1;
        tgt_alt  += 1;
        wait_drain(100);
        repeat (10) @(negedge clk);
        check("bist_alt_blocked_busy", 32'(busy), 32'd0);
        check("bist_alt_blocked_count", 32'(op_count), 32'd1);
        expect_op(K_ALT, 0, 2, 3, 0);
        enable = 1'b1;
        wait_drain(100);

        // Watchdog: done on the 15th WAIT cycle wins, then a real abort.
        do_reset();
        enable = 1'b1;
        delay  = 15;
        expect_op(K_BAT, 1, 1, 16, 0);
        tgt_bat += 1;
        wait_drain(100);
        check("late_done_no_err", 32'(timeout_err), 32'd0);
        check("late_done_count", 32'(op_count), 32'd1);
        delay = 0;
        expect_op(K_ERR, 1, 1, 16, 0);
        tgt_bat += 1;
        wait_drain(100);
        check("abort_timeout_err", 32'(timeout_err), 32'd1);
        check("abort_count_held", 32'(op_count), 32'd1);
        delay = 1;
        expect_op(K_ALT, 0, 2, 2, 0);
        tgt_alt += 1;
        wait_drain(100);
        check("timeout_err_sticky", 32'(timeout_err), 32'd1);
        check("after_abort_count", 32'(op_count), 32'd2);

        // Reset during WAIT with battery in flight (last_served is altitude).
        delay = 0;
        tgt_bat += 1;
        seen = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (dp_start) begin
                seen = 1'b1;
                break;
            end
        end
        check("inflight_started", 32'(seen), 32'd1);
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_busy", 32'(busy), 32'd0);
        check("async_rst_dp_sel", 32'(dp_sel), 32'd0);
        check("async_rst_op_count", 32'(op_count), 32'd0);
        check("async_rst_timeout_err", 32'(timeout_err), 32'd0);
        check("async_rst_pulses",
              32'({dp_start, done_alt, done_bat, done_bist, err_pulse}), 32'd0);
        delay = 2;
        tgt_alt += 1;
        expect_op(K_ALT, 0, 1, 3, 0);
        expect_op(K_BAT, 1, 2, 3, 5);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        wait_drain(100);

        // op_count wraps after 256 completions.
        do_reset();
        enable = 1'b1;
        delay  = 1;
        for (int i = 1; i <= 256; i++) begin
            expect_op(K_ALT, 0, i % 256, 2, (i > 1) ? 4 : 0);
        end
        tgt_alt += 256;
        wait_drain(1500);
        check("wrap_op_count", 32'(op_count), 32'd0);

        repeat (5) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
